spi_master_avalon_tx: RTL and testbench
=======================================

Name: spi_master_avalon_tx

Overview:
SPI initiator that feeds SpiBuffer-style receivers from an Avalon-MM register interface. Software writes bytes into a small TX FIFO, each tagged with an end-of-frame flag. The block generates CS, CLK and DI in the convention SpiBuffer expects: CS low while selected, CLK idle high, MSB first, data stable across each CLK rising edge. A status register and a frame counter are readable over the same Avalon port.

Parameters:
CLK_DIV, 2, system clocks per SPI CLK half-period (>=1)
FIFO_DEPTH, 4, TX FIFO entries (power of two, 2..16)
CS_GAP, 2, SPI CLK periods CS held high after an end-of-frame byte

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
io_Avalon_address  in  2  register select
io_Avalon_write  in  1  write strobe
io_Avalon_writedata  in  32  write data
io_Avalon_read  in  1  read strobe
io_Avalon_readdata  out  32  read data, registered
io_SpiCS  out  1  chip select, active low
io_SpiCLK  out  1  SPI clock, idle high
io_SpiDI  out  1  serial data to slave DI

Behaviour:
- Reset (reset=0, async): io_SpiCS=1, io_SpiCLK=1, io_SpiDI=0, io_Avalon_readdata=0. FIFO empty, overflow=0, frame counter=0, state IDLE.
- Register map, write:
  - addr0: push {writedata[8]=last, writedata[7:0]=byte}.
  - addr1: writedata[0]=1 clears overflow.
  - addr2, addr3: ignored.
- Register map, read (data valid on the cycle after io_Avalon_read):
  - addr0: 0.
  - addr1 status: bit0 empty, bit1 full, bit2 busy (state!=IDLE), bit3 overflow, [12:8] FIFO count; all other bits 0.
  - addr2: frame counter[15:0], wraps at 16 bits.
  - addr3: 0.
- FIFO:
  - Write to a full FIFO is dropped and sets sticky overflow, unless a pop occurs in the same cycle; in that case the write is accepted.
  - A push and a pop in the same cycle leave the count unchanged.
- States:
  - IDLE: CS=1, CLK=1. On FIFO non-empty, pop the entry, drive DI=byte[7], enter SETUP.
  - SETUP: CS=0, CLK=1, lasts CLK_DIV cycles, then enter SHIFT.
  - SHIFT: 8 bits, MSB first.
    - Each bit is a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles.
    - DI changes only at the falling edge (start of the low phase); bit 7 is already set in IDLE/WAIT.
    - The slave samples on the rising edge.
    - After the high phase of bit 0, go to NEXT.
  - NEXT (0 cycles, decision only):
    - If last=1: increment frame counter, enter GAP.
    - Else if FIFO non-empty: pop, continue SHIFT with no extra delay.
    - Else: enter WAIT.
  - WAIT: CS=0, CLK=1. On FIFO non-empty, pop, drive DI=byte[7], enter SHIFT.
  - GAP: CS=1, CLK=1 for CS_GAP*2*CLK_DIV cycles, then IDLE. Entries pushed during GAP wait until IDLE.
- Timing:
  - A one-byte frame holds CS low for CLK_DIV + 16*CLK_DIV cycles (34 at defaults).
  - Back-to-back bytes in one frame give exactly 16 contiguous rising edges per 2 bytes, with no stretched CLK high phase.
- io_SpiCLK, io_SpiCS and io_SpiDI are driven straight from flops, with no glitches.
- Reset asserted mid-frame: outputs return to reset values immediately. The FIFO and the partial byte are discarded; no rising edge is completed.
- CLK_DIV=1: each phase is one cycle; behaviour is otherwise identical.

Test Plan:
- Reset: drive reset=0 mid-sim -> CS=1, CLK=1, DI=0; status read returns 0x00000001; addr2 read returns 0.
- Single byte: write addr0=0x17A (0x7A, last) -> CS low for 34 cycles; DI at the 8 rising edges is 0,1,1,1,1,0,1,0; CS high for 8 cycles after; frame counter=1. A SpiBuffer on the outputs reports Buffer=122 with Changed.
- Two-byte frame: write 0x00C then 0x140 -> one CS-low window with 16 rising edges carrying 0x0C then 0x40, no gap between bytes; frame counter +1.
- Underrun: write 0x0AA (not last), wait 100 cycles, write 0x155 -> CS stays low, CLK high during the stall; second byte shifts after the write; frame ends after 0x55.
- Overflow: while the first byte shifts, write 6 entries (DEPTH=4) -> status full=1, overflow=1, count=4; write addr1=1 -> overflow=0; the remaining bytes are transmitted in order.
- Reset mid-byte: assert reset after the 3rd rising edge -> CS=1, CLK=1 at once; status empty after release; no further edges.

Source files
------------

// File: rtl/spi_master_avalon_tx.sv
// -----------------------------------------------------------------------------
// spi_master_avalon_tx
//
// SPI initiator fed from an Avalon-MM register port. Software pushes bytes into
// a small TX FIFO, each tagged with an end-of-frame flag. The engine drives
// chip select, clock and data in the SpiBuffer convention: CS active low,
// CLK idle high, MSB first, DI changed on falling edges and sampled by the
// slave on rising edges.
//
// Parameters:
//   CLK_DIV    system clocks per SPI CLK half-period (>= 1)
//   FIFO_DEPTH TX FIFO entries (power of two, 2..16)
//   CS_GAP     SPI CLK periods CS is held high after an end-of-frame byte
//
// Ports:
//   clock                system clock
//   reset                asynchronous, active-low reset
//   io_Avalon_address    register select (0 data, 1 status, 2 frame count)
//   io_Avalon_write      write strobe
//   io_Avalon_writedata  write data ({last, byte} for address 0)
//   io_Avalon_read       read strobe
//   io_Avalon_readdata   registered read data, valid the cycle after read
//   io_SpiCS             chip select, active low
//   io_SpiCLK            SPI clock, idle high
//   io_SpiDI             serial data towards the slave
// -----------------------------------------------------------------------------
module spi_master_avalon_tx #(
    parameter int CLK_DIV    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CS_GAP     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  io_Avalon_address,
    input  logic        io_Avalon_write,
    input  logic [31:0] io_Avalon_writedata,
    input  logic        io_Avalon_read,
    output logic [31:0] io_Avalon_readdata,
    output logic        io_SpiCS,
    output logic        io_SpiCLK,
    output logic        io_SpiDI
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(CS_GAP * 2 * CLK_DIV - 1);

    // NEXT from the behavioural description takes no cycle, so it is folded
    // into the end of the last SHIFT high phase rather than being a state.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_WAIT,
        ST_GAP
    } state_t;

    state_t state_q, state_d;

    logic [8:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty, fifo_full;
    logic [8:0]       fifo_head;
    logic             push_req, push_ok, pop, clear_ovf, overflow;

    logic [15:0] div_q, div_d;
    logic        half_q, half_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        last_q, last_d;
    logic [15:0] frame_q, frame_d;
    logic        cs_d, clk_d, di_d;
    logic [31:0] status_word;

    logic unused_wdata;
    assign unused_wdata = ^io_Avalon_writedata[31:9];

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_head  = fifo_mem[rd_ptr];
    assign push_req   = io_Avalon_write && (io_Avalon_address == 2'd0);
    assign clear_ovf  = io_Avalon_write && (io_Avalon_address == 2'd1) && io_Avalon_writedata[0];
    // A write to a full FIFO still lands when the engine frees a slot in the
    // same cycle; the head is read combinationally before the slot is reused.
    assign push_ok    = push_req && (!fifo_full || pop);

    // FIFO storage has no reset; only the pointers and count define contents.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= io_Avalon_writedata[8:0];
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (!push_ok && pop) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // State register plus the SPI pins. The pins are registered copies of
    // what the next state implies, so they come straight from flops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            half_q    <= 1'b0;
            bit_q     <= '0;
            shreg_q   <= '0;
            last_q    <= 1'b0;
            frame_q   <= '0;
            io_SpiCS  <= 1'b1;
            io_SpiCLK <= 1'b1;
            io_SpiDI  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            half_q    <= half_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            last_q    <= last_d;
            frame_q   <= frame_d;
            io_SpiCS  <= cs_d;
            io_SpiCLK <= clk_d;
            io_SpiDI  <= di_d;
        end
    end

    // Next-state logic. div counts system clocks inside SETUP, each SHIFT
    // half-period and GAP; half_q selects the low (0) or high (1) phase.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        half_d  = half_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        last_d  = last_q;
        frame_d = frame_q;
        di_d    = io_SpiDI;
        pop     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_head[7:0];
                    last_d  = fifo_head[8];
                    di_d    = fifo_head[7];
                    div_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    half_d  = 1'b0;
                    bit_d   = 3'd7;
                    state_d = ST_SHIFT;
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            ST_SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + 16'd1;
                end else begin
                    div_d = '0;
                    if (!half_q) begin
                        half_d = 1'b1;
                    end else if (bit_q != 3'd0) begin
                        // Falling edge: present the next bit.
                        half_d  = 1'b0;
                        bit_d   = bit_q - 3'd1;
                        shreg_d = {shreg_q[6:0], 1'b0};
                        di_d    = shreg_q[6];
                    end else if (last_q) begin
                        frame_d = frame_q + 16'd1;
                        state_d = ST_GAP;
                    end else if (!fifo_empty) begin
                        // Chain the next byte without stretching CLK high.
                        pop     = 1'b1;
                        shreg_d = fifo_head[7:0];
                        last_d  = fifo_head[8];
                        di_d    = fifo_head[7];
                        half_d  = 1'b0;
                        bit_d   = 3'd7;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_head[7:0];
                    last_d  = fifo_head[8];
                    di_d    = fifo_head[7];
                    div_d   = '0;
                    half_d  = 1'b0;
                    bit_d   = 3'd7;
                    state_d = ST_SHIFT;
                end
            end
            ST_GAP: begin
                if (div_q == GAP_LAST) begin
                    div_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cs_d  = !((state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_WAIT));
        clk_d = !((state_d == ST_SHIFT) && !half_d);
    end

    // Status word assembled from live FIFO and engine state.
    always_comb begin
        status_word       = '0;
        status_word[0]    = fifo_empty;
        status_word[1]    = fifo_full;
        status_word[2]    = (state_q != ST_IDLE);
        status_word[3]    = overflow;
        status_word[12:8] = 5'(fifo_count);
    end

    // Registered read port; holds its value between reads.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_Avalon_readdata <= '0;
        end else if (io_Avalon_read) begin
            unique case (io_Avalon_address)
                2'd1:    io_Avalon_readdata <= status_word;
                2'd2:    io_Avalon_readdata <= {16'd0, frame_q};
                default: io_Avalon_readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_avalon_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_master_avalon_tx
//
// Directed sequence with randomized payload bytes. A SpiBuffer-like receiver
// watches the SPI pins and collects bytes, frame lengths and CS-high gaps;
// expected bytes come from a queue filled as software writes are modelled.
// -----------------------------------------------------------------------------
module tb_spi_master_avalon_tx;

    localparam int CLK_DIV    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int CS_GAP     = 2;
    localparam int BYTE_LEN   = 16 * CLK_DIV;
    localparam int GAP_LEN    = 2 * CS_GAP * CLK_DIV;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  io_Avalon_address = '0;
    logic        io_Avalon_write = 1'b0;
    logic [31:0] io_Avalon_writedata = '0;
    logic        io_Avalon_read = 1'b0;
    logic [31:0] io_Avalon_readdata;
    logic        io_SpiCS, io_SpiCLK, io_SpiDI;

    spi_master_avalon_tx #(
        .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .CS_GAP(CS_GAP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .io_Avalon_address(io_Avalon_address),
        .io_Avalon_write(io_Avalon_write),
        .io_Avalon_writedata(io_Avalon_writedata),
        .io_Avalon_read(io_Avalon_read),
        .io_Avalon_readdata(io_Avalon_readdata),
        .io_SpiCS(io_SpiCS),
        .io_SpiCLK(io_SpiCLK),
        .io_SpiDI(io_SpiDI)
    );

    always #5 clock = ~clock;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Receiver state, sampled on the falling system clock edge.
    logic       prev_sclk = 1'b1;
    logic       prev_cs   = 1'b1;
    logic [7:0] rx_shift  = '0;
    int rx_bits = 0, frame_edges = 0, cs_low_len = 0, cs_high_run = 0;
    int total_edges = 0, frames_seen = 0, last_len = 0, last_edges = 0, last_gap = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int exp_frames = 0;

    always @(negedge clock) begin
        if (!reset) begin
            rx_bits     = 0;
            frame_edges = 0;
            cs_low_len  = 0;
            prev_sclk   = 1'b1;
            prev_cs     = 1'b1;
        end else begin
            if (!io_SpiCS) begin
                if (prev_cs) last_gap = cs_high_run;
                cs_low_len++;
                if (!prev_sclk && io_SpiCLK) begin
                    rx_shift = {rx_shift[6:0], io_SpiDI};
                    rx_bits++;
                    frame_edges++;
                    total_edges++;
                    if (rx_bits == 8) begin
                        rx_q.push_back(rx_shift);
                        rx_bits = 0;
                    end
                end
            end else if (!prev_cs) begin
                frames_seen++;
                last_len    = cs_low_len;
                last_edges  = frame_edges;
                cs_low_len  = 0;
                frame_edges = 0;
                rx_bits     = 0;
                cs_high_run = 1;
            end else begin
                cs_high_run++;
            end
            prev_sclk = io_SpiCLK;
            prev_cs   = io_SpiCS;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clock);
        io_Avalon_address   = addr;
        io_Avalon_writedata = data;
        io_Avalon_write     = 1'b1;
        @(negedge clock);
        io_Avalon_write     = 1'b0;
    endtask

    task automatic avalon_read(input logic [1:0] addr, output logic [31:0] data);
        @(negedge clock);
        io_Avalon_address = addr;
        io_Avalon_read    = 1'b1;
        @(negedge clock);
        io_Avalon_read    = 1'b0;
        data = io_Avalon_readdata;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic last);
        apply_stimulus(2'd0, {23'd0, last, b});
    endtask

    task automatic wait_frames(input string tag, input int target, input int budget);
        int n = 0;
        while (frames_seen < target && n < budget) begin
            @(negedge clock);
            n++;
        end
        check_output(tag, 32'(frames_seen), 32'(target));
    endtask

    task automatic check_rx(input string tag);
        logic [7:0] e;
        logic [8:0] o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (rx_q.size() > 0) ? {1'b0, rx_q.pop_front()} : 9'h100;
            check_output(tag, 32'(o), 32'(e));
        end
        check_output({tag, "_extra"}, 32'(rx_q.size()), 32'd0);
    endtask

    function automatic logic [31:0] status_of(input int count, input logic busy,
                                              input logic ovf);
        return 32'(count) * 256 + (ovf ? 8 : 0) + (busy ? 4 : 0)
             + ((count == FIFO_DEPTH) ? 2 : 0) + ((count == 0) ? 1 : 0);
    endfunction

    initial begin
        logic [31:0] rd;
        logic [7:0]  b;
        int nbytes [2];
        int occ;
        logic ovf;
        int snap_edges, snap_frames, n;

        // Reset values while held in reset.
        repeat (3) @(negedge clock);
        check_output("reset_cs", 32'(io_SpiCS), 32'd1);
        check_output("reset_clk", 32'(io_SpiCLK), 32'd1);
        check_output("reset_di", 32'(io_SpiDI), 32'd0);
        check_output("reset_rdata", io_Avalon_readdata, 32'd0);
        reset = 1'b1;
        avalon_read(2'd1, rd);
        check_output("reset_status", rd, 32'h1);
        avalon_read(2'd2, rd);
        check_output("reset_frames", rd, 32'd0);
        avalon_read(2'd3, rd);
        check_output("addr3_zero", rd, 32'd0);

        // Single byte 0x7A with last set.
        $display("[TB] single byte frame");
        push_byte(8'h7A, 1'b1);
        exp_q.push_back(8'h7A);
        exp_frames++;
        wait_frames("single_done", exp_frames, 200);
        check_rx("single_byte");
        check_output("single_len", 32'(last_len), 32'(CLK_DIV + BYTE_LEN));
        check_output("single_edges", 32'(last_edges), 32'd8);
        n = 0;
        for (int i = 0; i < GAP_LEN; i++) begin
            @(negedge clock);
            if (io_SpiCS) n++;
        end
        check_output("single_gap_high", 32'(n), 32'(GAP_LEN));
        avalon_read(2'd2, rd);
        check_output("single_frames", rd, 32'(exp_frames));
        avalon_read(2'd0, rd);
        check_output("addr0_zero", rd, 32'd0);

        // Two queued random frames of 1..2 bytes; the CS-high gap between
        // them is the GAP time plus the one IDLE cycle that pops the entry.
        $display("[TB] random queued frames");
        for (int f = 0; f < 2; f++) begin
            nbytes[f] = int'($urandom_range(1, 2));
            for (int i = 0; i < nbytes[f]; i++) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                push_byte(b, i == nbytes[f] - 1);
            end
        end
        for (int f = 0; f < 2; f++) begin
            exp_frames++;
            wait_frames("rand_done", exp_frames, 400);
            check_output("rand_len", 32'(last_len), 32'(CLK_DIV + nbytes[f] * BYTE_LEN));
            check_output("rand_edges", 32'(last_edges), 32'(8 * nbytes[f]));
        end
        check_output("rand_gap", 32'(last_gap), 32'(GAP_LEN + 1));
        check_rx("rand_bytes");

        // Two-byte frame 0x0C then 0x40, no gap between bytes.
        $display("[TB] two byte frame");
        repeat (GAP_LEN + 4) @(negedge clock);
        push_byte(8'h0C, 1'b0);
        push_byte(8'h40, 1'b1);
        exp_q.push_back(8'h0C);
        exp_q.push_back(8'h40);
        exp_frames++;
        wait_frames("two_done", exp_frames, 300);
        check_output("two_len", 32'(last_len), 32'(CLK_DIV + 2 * BYTE_LEN));
        check_output("two_edges", 32'(last_edges), 32'd16);
        check_rx("two_bytes");
        avalon_read(2'd2, rd);
        check_output("two_frames", rd, 32'(exp_frames));

        // Underrun: CS stays low with CLK high until the next byte arrives.
        $display("[TB] underrun");
        repeat (GAP_LEN + 4) @(negedge clock);
        push_byte(8'hAA, 1'b0);
        repeat (100) @(negedge clock);
        check_output("stall_cs", 32'(io_SpiCS), 32'd0);
        check_output("stall_clk", 32'(io_SpiCLK), 32'd1);
        avalon_read(2'd1, rd);
        check_output("stall_status", rd, status_of(0, 1'b1, 1'b0));
        push_byte(8'h55, 1'b1);
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        exp_frames++;
        wait_frames("stall_done", exp_frames, 300);
        check_output("stall_edges", 32'(last_edges), 32'd16);
        check_rx("stall_bytes");

        // Overflow: six writes while the first byte shifts.
        $display("[TB] overflow");
        repeat (GAP_LEN + 4) @(negedge clock);
        b = 8'($urandom);
        exp_q.push_back(b);
        push_byte(b, 1'b0);
        n = 0;
        while (io_SpiCS && n < 20) begin
            @(negedge clock);
            n++;
        end
        check_output("ovf_started", 32'(io_SpiCS), 32'd0);
        occ = 0;
        ovf = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            b = 8'($urandom);
            if (occ < FIFO_DEPTH) begin
                exp_q.push_back(b);
                occ++;
            end else begin
                ovf = 1'b1;
            end
            push_byte(b, i == FIFO_DEPTH);
        end
        avalon_read(2'd1, rd);
        check_output("ovf_status", rd, status_of(occ, 1'b1, ovf));
        apply_stimulus(2'd1, 32'd1);
        avalon_read(2'd1, rd);
        check_output("ovf_cleared", rd, status_of(occ, 1'b1, 1'b0));
        exp_frames++;
        wait_frames("ovf_done", exp_frames, 600);
        check_output("ovf_edges", 32'(last_edges), 32'(8 * (FIFO_DEPTH + 1)));
        check_rx("ovf_bytes");
        avalon_read(2'd2, rd);
        check_output("ovf_frames", rd, 32'(exp_frames));

        // Reset after the third rising edge of a byte.
        $display("[TB] reset mid byte");
        repeat (GAP_LEN + 4) @(negedge clock);
        push_byte(8'($urandom), 1'b1);
        n = 0;
        while (frame_edges < 3 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check_output("mid_edges", 32'(frame_edges), 32'd3);
        snap_edges  = total_edges;
        snap_frames = frames_seen;
        #2 reset = 1'b0;
        #1;
        check_output("mid_cs", 32'(io_SpiCS), 32'd1);
        check_output("mid_clk", 32'(io_SpiCLK), 32'd1);
        check_output("mid_di", 32'(io_SpiDI), 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        avalon_read(2'd1, rd);
        check_output("mid_status", rd, 32'h1);
        avalon_read(2'd2, rd);
        check_output("mid_frames_reg", rd, 32'd0);
        repeat (50) @(negedge clock);
        check_output("mid_no_edges", 32'(total_edges), 32'(snap_edges));
        check_output("mid_no_frame", 32'(frames_seen), 32'(snap_frames));
        check_output("mid_no_byte", 32'(rx_q.size()), 32'd0);

        // Recovery frame after reset.
        b = 8'($urandom);
        exp_q.push_back(b);
        push_byte(b, 1'b1);
        wait_frames("post_done", snap_frames + 1, 200);
        check_output("post_len", 32'(last_len), 32'(CLK_DIV + BYTE_LEN));
        check_rx("post_byte");
        avalon_read(2'd2, rd);
        check_output("post_frames", rd, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
